// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: shared types and default constants for the clock period meter.
//   state_e     : meter FSM states
//   DEF_EXPECT  : nominal period in basys_clk cycles (20 Hz at 100 MHz)
//   DEF_TOL     : allowed absolute deviation from the nominal period
//   DEF_TIMEOUT : cycles without a rise before the input counts as lost
//   LOCK_N      : consecutive in-tolerance periods needed for lock
package clk_meter_pkg;
    typedef enum logic [1:0] {IDLE, MEASURE, TRACK, LOST} state_e;
    localparam int DEF_EXPECT  = 5000000;
    localparam int DEF_TOL     = 1000;
    localparam int DEF_TIMEOUT = 10000000;
    localparam int LOCK_N      = 2;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchroniser with registered single-cycle edge ticks.
//   clk   in  : sampling clock
//   rst_n in  : asynchronous active-low reset
//   din   in  : asynchronous slow input
//   rise  out : one-cycle pulse per rising edge of din
//   fall  out : one-cycle pulse per falling edge of din
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic s0_q, s1_q, s2_q, rise_q, fall_q;
    logic s0_d, s1_d, s2_d, rise_d, fall_d;

    always_comb begin
        s0_d   = din;
        s1_d   = s0_q;
        s2_d   = s1_q;
        rise_d = s1_q & ~s2_q;
        fall_d = ~s1_q & s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q   <= 1'b0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the rise-to-rise period of a slow square wave in basys_clk cycles.
//   basys_clk    in  : system clock
//   rst_n        in  : asynchronous active-low reset
//   clk_in       in  : slow square wave, asynchronous to basys_clk
//   rise_tick    out : one-cycle pulse per clk_in rising edge
//   fall_tick    out : one-cycle pulse per clk_in falling edge
//   period       out : last valid rise-to-rise interval
//   period_valid out : one-cycle pulse when period updates
//   locked       out : period within tolerance for LOCK_N consecutive measurements
//   lost         out : no rise seen for TIMEOUT cycles
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int EXPECT  = DEF_EXPECT,
    parameter int TOL     = DEF_TOL,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             basys_clk,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);
    localparam logic [CNT_W-1:0]   TO_C    = CNT_W'(TIMEOUT);
    localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXPECT);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);
    localparam logic [1:0]         LOCK_M1 = 2'(LOCK_N - 1);

    logic rise, fall, in_tol;
    logic signed [CNT_W:0] diff;
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic [1:0] match_q, match_d;
    logic valid_q, valid_d, locked_q, locked_d;

    sync_edge_det u_sync (
        .clk   (basys_clk),
        .rst_n (rst_n),
        .din   (clk_in),
        .rise  (rise),
        .fall  (fall)
    );

    // cnt holds the interval ending in the current rise_tick cycle, so it is the period directly
    assign diff   = $signed({1'b0, cnt_q}) - EXP_S;
    assign in_tol = (diff <= TOL_S) && (diff >= -TOL_S);

    always_comb begin
        state_d  = state_q;
        cnt_d    = rise ? CNT_W'(1) : (cnt_q == TO_C) ? cnt_q : cnt_q + 1'b1;
        period_d = period_q;
        valid_d  = 1'b0;
        match_d  = match_q;
        locked_d = locked_q;
        if (rise) begin
            state_d = (state_q == IDLE || state_q == LOST) ? MEASURE : TRACK;
            if (state_q == TRACK) begin
                period_d = cnt_q;
                valid_d  = 1'b1;
                match_d  = !in_tol ? 2'd0 : (match_q == 2'd3) ? match_q : match_q + 2'd1;
                locked_d = in_tol && (match_q >= LOCK_M1);
            end
        end else if (cnt_q == TO_C && state_q != LOST) begin
            state_d  = LOST;
            match_d  = 2'd0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge basys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            match_q  <= 2'd0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
            locked_q <= locked_d;
        end
    end

    assign rise_tick    = rise;
    assign fall_tick    = fall;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign lost         = (state_q == LOST);
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed and randomized check of clk_period_meter against a timestamp model.
module tb_clk_period_meter;
    localparam int CNT_W = 8, EXPECT = 20, TOL = 1, TIMEOUT = 50;

    logic basys_clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_in = 1'b0;
    logic rise_tick, fall_tick, period_valid, locked, lost;
    logic [CNT_W-1:0] period;

    int n_cmp = 0, n_bad = 0;
    string phase = "reset";

    // model: edge index since release, index of the edge that produced the last rise tick
    int h[$];
    int m_j, m_a, m_rises, m_match, m_period;
    logic m_lost, m_locked, m_valid, m_rise, m_fall;

    clk_period_meter #(.CNT_W(CNT_W), .EXPECT(EXPECT), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
        .basys_clk    (basys_clk),
        .rst_n        (rst_n),
        .clk_in       (clk_in),
        .rise_tick    (rise_tick),
        .fall_tick    (fall_tick),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    always #5 basys_clk = ~basys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s/%s: observed %0d, expected %0d", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_j = 0; m_a = 0; m_rises = 0; m_match = 0; m_period = 0;
        m_lost = 0; m_locked = 0; m_valid = 0; m_rise = 0; m_fall = 0;
        h.delete();
        repeat (4) h.push_back(0);
    endtask

    // Outputs after edge j, given the clk_in sample taken at that edge.
    task automatic model_edge(input int v);
        int n, gap, d;
        logic rp;
        h.push_back(v);
        if (h.size() > 8) h.delete(0);
        m_j++;
        rp = m_rise;
        m_valid = 0;
        if (rp) begin
            gap = (m_j - 1) - m_a;
            if (gap > TIMEOUT) gap = TIMEOUT;
            m_rises++;
            if (m_rises >= 3) begin
                m_valid = 1;
                m_period = gap;
                d = gap - EXPECT;
                if (d < 0) d = -d;
                if (d <= TOL) m_match++;
                else m_match = 0;
                m_locked = (m_match >= 2);
            end
            m_lost = 0;
            m_a = m_j - 1;
        end else if (!m_lost && (m_j - 1) - m_a >= TIMEOUT) begin
            m_lost = 1; m_locked = 0; m_match = 0; m_rises = 0;
        end
        n = h.size();
        m_rise = (h[n-3] == 1) && (h[n-4] == 0);
        m_fall = (h[n-3] == 0) && (h[n-4] == 1);
    endtask

    task automatic check_all();
        chk("rise_tick", 32'(rise_tick), 32'(m_rise));
        chk("fall_tick", 32'(fall_tick), 32'(m_fall));
        chk("period", 32'(period), 32'(m_period));
        chk("period_valid", 32'(period_valid), 32'(m_valid));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("lost", 32'(lost), 32'(m_lost));
    endtask

    task automatic tick(input logic v, input logic r);
        @(negedge basys_clk);
        clk_in = v;
        rst_n = r;
        @(posedge basys_clk);
        if (r) model_edge(int'(v));
        else model_reset();
        #1 check_all();
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        repeat (reps) begin
            repeat (hi) tick(1'b1, 1'b1);
            repeat (lo) tick(1'b0, 1'b1);
        end
    endtask

    initial begin
        model_reset();
        // reset held with clk_in toggling, then release low: lost on the 51st cycle
        repeat (8) tick(1'($urandom_range(0, 1)), 1'b0);
        phase = "idle_timeout";
        for (int k = 1; k <= 55; k++) begin
            tick(1'b0, 1'b1);
            if (k == 50) chk("lost_at_50", 32'(lost), 32'd0);
            if (k == 51) chk("lost_at_51", 32'(lost), 32'd1);
        end
        phase = "square_20";
        wave(10, 10, 6);
        chk("locked_after_20s", 32'(locked), 32'd1);
        phase = "period_23";
        wave(12, 11, 2);
        phase = "back_to_20";
        wave(10, 10, 4);
        phase = "loss";
        repeat (60) tick(1'b0, 1'b1);
        chk("lost_held_low", 32'(lost), 32'd1);
        phase = "resume";
        wave(10, 10, 4);
        phase = "timeout_edge";
        wave(25, 25, 3);
        phase = "timeout_over";
        wave(25, 26, 2);
        phase = "random";
        repeat (20) wave($urandom_range(1, 14), $urandom_range(1, 14), 1);
        repeat (10) wave(10, $urandom_range(9, 11), 1);
        phase = "mid_reset";
        wave(10, 10, 4);
        repeat (5) tick(1'b1, 1'b1);
        chk("locked_pre_reset", 32'(locked), 32'(m_locked));
        #3 rst_n = 1'b0;
        #1;
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_period", 32'(period), 32'd0);
        chk("async_rise", 32'(rise_tick), 32'd0);
        chk("async_fall", 32'(fall_tick), 32'd0);
        chk("async_valid", 32'(period_valid), 32'd0);
        chk("async_lost", 32'(lost), 32'd0);
        repeat (4) tick(1'($urandom_range(0, 1)), 1'b0);
        phase = "after_reset";
        wave(10, 10, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
